// File: rtl/img_pkg.sv
// Shared image geometry and the pixel-to-frame packer state encoding.
package img_pkg;

  localparam int IMG_R_I = 5;
  localparam int IMG_C_I = 5;
  localparam int IMG_W_I = 8;
  localparam int FRAME_W = IMG_R_I * IMG_C_I * IMG_W_I;

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_DROP = 1'b1;

endpackage

// File: rtl/axis_pixel_to_frame.sv
// Packs a raster AXIS pixel stream into flat R_I*C_I*W_I frame beats; a fill
// register and an output register let packing of frame k+1 overlap draining of frame k.
module axis_pixel_to_frame
  import img_pkg::*;
#(
  parameter int R_I = IMG_R_I,
  parameter int C_I = IMG_C_I,
  parameter int W_I = IMG_W_I
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     s_axis_pixel_ready,
  input  logic                     s_axis_pixel_valid,
  input  logic [W_I-1:0]           s_axis_pixel_data,
  input  logic                     s_axis_pixel_last,
  input  logic                     m_axis_frame_ready,
  output logic                     m_axis_frame_valid,
  output logic [R_I*C_I*W_I-1:0]   m_axis_frame_data,
  output logic                     err_runt,
  output logic                     err_long
);

  localparam int N_PIX = R_I * C_I;
  localparam int CW    = (N_PIX > 1) ? $clog2(N_PIX) : 1;
  localparam int FW    = N_PIX * W_I;
  localparam logic [CW-1:0] LAST_IDX = CW'(N_PIX - 1);

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [FW-1:0] fill_q, fill_d;
  logic          fill_full_q, fill_full_d;
  logic [FW-1:0] out_q, out_d;
  logic          out_vld_q, out_vld_d;
  logic          err_runt_q, err_runt_d;
  logic          err_long_q, err_long_d;

  logic          out_free;
  logic          acc;
  logic          at_last_idx;
  logic [FW-1:0] merged;

  assign out_free           = !out_vld_q | m_axis_frame_ready;
  assign s_axis_pixel_ready = !fill_full_q & !rst;
  assign acc                = s_axis_pixel_valid & s_axis_pixel_ready;
  assign at_last_idx        = (cnt_q == LAST_IDX);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fill_d      = fill_q;
    fill_full_d = fill_full_q;
    out_d       = out_q;
    out_vld_d   = out_vld_q & !m_axis_frame_ready;
    err_runt_d  = 1'b0;
    err_long_d  = 1'b0;

    merged = fill_q;
    merged[W_I*int'(cnt_q) +: W_I] = s_axis_pixel_data;

    // A parked frame moves to the output as soon as the output slot frees up.
    // Input is stalled while it is parked, so this never collides with acc below.
    if (fill_full_q && out_free) begin
      out_d       = fill_q;
      out_vld_d   = 1'b1;
      fill_full_d = 1'b0;
    end

    if (acc) begin
      if (state_q == ST_FILL) begin
        if (at_last_idx) begin
          cnt_d = '0;
          if (out_free) begin
            out_d     = merged;
            out_vld_d = 1'b1;
          end else begin
            fill_d      = merged;
            fill_full_d = 1'b1;
          end
          if (!s_axis_pixel_last) begin
            err_long_d = 1'b1;
            state_d    = ST_DROP;
          end
        end else if (s_axis_pixel_last) begin
          cnt_d      = '0;
          err_runt_d = 1'b1;
        end else begin
          fill_d = merged;
          cnt_d  = cnt_q + 1'b1;
        end
      end else if (s_axis_pixel_last) begin
        state_d = ST_FILL;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FILL;
      cnt_q       <= '0;
      fill_q      <= '0;
      fill_full_q <= 1'b0;
      out_q       <= '0;
      out_vld_q   <= 1'b0;
      err_runt_q  <= 1'b0;
      err_long_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fill_q      <= fill_d;
      fill_full_q <= fill_full_d;
      out_q       <= out_d;
      out_vld_q   <= out_vld_d;
      err_runt_q  <= err_runt_d;
      err_long_q  <= err_long_d;
    end
  end

  assign m_axis_frame_valid = out_vld_q;
  assign m_axis_frame_data  = out_q;
  assign err_runt           = err_runt_q;
  assign err_long           = err_long_q;

endmodule

// File: tb/tb_axis_pixel_to_frame.sv
// Randomized bench for axis_pixel_to_frame: packet-level reference model plus
// directed cases for latency, back-pressure, runt/long frames and mid-frame reset.
module tb_axis_pixel_to_frame;
  import img_pkg::*;

  localparam int N_PIX = IMG_R_I * IMG_C_I;
  localparam int W     = IMG_W_I;
  localparam int FW    = FRAME_W;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_ready, s_valid, s_last;
  logic [W-1:0]  s_data;
  logic          m_ready, m_valid;
  logic [FW-1:0] m_data;
  logic          err_runt, err_long;

  axis_pixel_to_frame dut (
    .clk                (clk),
    .rst                (rst),
    .s_axis_pixel_ready (s_ready),
    .s_axis_pixel_valid (s_valid),
    .s_axis_pixel_data  (s_data),
    .s_axis_pixel_last  (s_last),
    .m_axis_frame_ready (m_ready),
    .m_axis_frame_valid (m_valid),
    .m_axis_frame_data  (m_data),
    .err_runt           (err_runt),
    .err_long           (err_long)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int exp_runt = 0, exp_long = 0, obs_runt = 0, obs_long = 0;
  int sink_mode = 0;  // 0 always ready, 1 never ready, 2 random
  logic [FW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic finish_sim();
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  endtask

  // Sink ready generator
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (sink_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'b0;
        default: m_ready = ($urandom_range(0, 9) < 7);
      endcase
    end
  end

  // Output monitor: in-order scoreboard, stall stability, error pulse counting
  initial begin
    logic          stall;
    logic [FW-1:0] prev;
    stall = 1'b0;
    prev  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("stall_valid", FW'(m_valid), FW'(1));
          chk("stall_data", m_data, prev);
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) chk("unexpected_frame", FW'(m_valid), FW'(0));
          else chk("frame", m_data, exp_q.pop_front());
        end
        if (err_runt || err_long) chk("err_exclusive", FW'(err_runt & err_long), FW'(0));
        if (err_runt) obs_runt++;
        if (err_long) obs_long++;
        stall = m_valid && !m_ready;
        prev  = m_data;
      end
    end
  end

  // Send send_n beats of a len-beat packet; tlast on beat len-1. Expectations
  // follow the packet rules: first N_PIX pixels form a frame, shorter is a runt.
  task automatic send_pkt(input int len, input int kind, input logic [W-1:0] v,
                          input int send_n, input bit thr);
    logic [FW-1:0] f;
    f = '0;
    for (int i = 0; i < send_n; i++) begin
      logic [W-1:0] p;
      int waited;
      p = (kind == 0) ? v : (kind == 1) ? W'(i + 1) : W'($urandom);
      if (thr) begin
        while ($urandom_range(0, 3) == 0) begin
          s_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      s_valid = 1'b1;
      s_data  = p;
      s_last  = (i == len - 1);
      waited  = 0;
      @(negedge clk);
      while (!s_ready) begin
        waited++;
        if (waited > 2000) begin
          chk("ready_timeout", FW'(s_ready), FW'(1));
          finish_sim();
        end
        @(negedge clk);
      end
      @(posedge clk); #1;
      if (i < N_PIX) f[i*W +: W] = p;
      if (i == N_PIX - 1) begin
        exp_q.push_back(f);
        if (len > N_PIX) exp_long++;
      end
      if (i == len - 1 && len < N_PIX) exp_runt++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_drained"}, FW'(exp_q.size()), FW'(0));
    chk({tag, "_runt_cnt"}, FW'(obs_runt), FW'(exp_runt));
    chk({tag, "_long_cnt"}, FW'(obs_long), FW'(exp_long));
  endtask

  initial begin
    logic [FW-1:0] f1;
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", FW'(s_ready), FW'(0));
    chk("rst_m_valid", FW'(m_valid), FW'(0));
    chk("rst_m_data", m_data, FW'(0));
    chk("rst_errs", FW'({err_runt, err_long}), FW'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", FW'(s_ready), FW'(1));
    @(posedge clk); #1;

    // Single frame, values 1..N_PIX, output one cycle after the last beat
    f1 = '0;
    for (int i = 0; i < N_PIX; i++) f1[i*W +: W] = W'(i + 1);
    send_pkt(N_PIX, 1, '0, N_PIX, 0);
    chk("latency_valid", FW'(m_valid), FW'(1));
    chk("latency_data", m_data, f1);
    drain("single");

    // Back-pressure: two frames buffered, input stalls, in-order delivery
    sink_mode = 1;
    @(posedge clk); #1;
    send_pkt(N_PIX, 0, 8'hAA, N_PIX, 0);
    send_pkt(N_PIX, 0, 8'h55, N_PIX, 0);
    chk("bp_ready_low", FW'(s_ready), FW'(0));
    repeat (40) @(posedge clk);
    #1;
    chk("bp_held_valid", FW'(m_valid), FW'(1));
    sink_mode = 0;
    drain("backpressure");

    // Runt then a good frame
    send_pkt(10, 0, 8'h99, 10, 0);
    send_pkt(N_PIX, 0, 8'h33, N_PIX, 0);
    drain("runt");

    // Long frame: first N_PIX pixels kept, excess dropped, next frame clean
    send_pkt(N_PIX + 5, 1, '0, N_PIX + 5, 0);
    send_pkt(N_PIX, 0, 8'h21, N_PIX, 0);
    drain("long");

    // Reset mid-frame discards the partial frame silently
    send_pkt(N_PIX, 0, 8'h11, 12, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", FW'(s_ready), FW'(0));
    @(posedge clk); #1;
    chk("mid_rst_valid", FW'(m_valid), FW'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready_back", FW'(s_ready), FW'(1));
    @(posedge clk); #1;
    send_pkt(N_PIX, 0, 8'h7F, N_PIX, 0);
    drain("reset");

    // Random throttling on both sides with occasional runt/long packets
    sink_mode = 2;
    for (int k = 0; k < 200; k++) begin
      int r, len;
      r = $urandom_range(0, 9);
      len = (r == 0) ? $urandom_range(1, N_PIX - 1) :
            (r == 1) ? $urandom_range(N_PIX + 1, N_PIX + 5) : N_PIX;
      send_pkt(len, 2, '0, len, 1);
    end
    drain("random");

    finish_sim();
  end

endmodule
